// File: rtl/sm_reg_uart_dump_if.sv
// Register-dump bus: start/busy/done handshake, register read port
// and the UART serial line. master = dumper, slave = core/host side.
interface sm_reg_uart_dump_if;
   logic        start;
   logic [4:0]  regAddr;
   logic [31:0] regData;
   logic        uart_tx;
   logic        busy;
   logic        done;

   modport master (
      input  start,
      input  regData,
      output regAddr,
      output uart_tx,
      output busy,
      output done
   );

   modport slave (
      output start,
      output regData,
      input  regAddr,
      input  uart_tx,
      input  busy,
      input  done
   );
endinterface

// File: rtl/sm_reg_uart_dump.sv
// Dumps registers 0..NUM_REGS-1 over an 8N1 UART as "AA:DDDDDDDD\r\n".
// Ports: clk, rst (sync, active high), bus (start/regAddr/regData/uart_tx/busy/done).
module sm_reg_uart_dump #(
   parameter int BAUD_DIV = 434,
   parameter int NUM_REGS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   sm_reg_uart_dump_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE,
      SETADDR,
      LATCH,
      SEND,
      NEXT
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [4:0]  ADDR_LAST = 5'(NUM_REGS - 1);

   state_t      state_q;
   logic [15:0] baud_q;
   logic [3:0]  bit_q;
   logic [3:0]  chr_q;
   logic [31:0] hold_q;
   logic [4:0]  addr_q;
   logic        tx_q;
   logic        busy_q;
   logic        done_q;

   logic [3:0]  nib;
   logic [2:0]  nib_idx;
   logic [7:0]  char_c;
   logic        tx_d;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // chr 3..10 walk the latched word from its top nibble down
   assign nib_idx = 3'(4'd10 - chr_q);

   always_comb begin
      nib    = hold_q[{nib_idx, 2'b00} +: 4];
      char_c = 8'h00;
      case (chr_q)
         4'd0:    char_c = hex({3'b000, addr_q[4]});
         4'd1:    char_c = hex(addr_q[3:0]);
         4'd2:    char_c = 8'h3A;
         4'd11:   char_c = 8'h0D;
         4'd12:   char_c = 8'h0A;
         default: char_c = hex(nib);
      endcase
   end

   // level of the bit that follows bit_q: data LSB first, then stop
   assign tx_d = (bit_q == 4'd8) ? 1'b1 : char_c[bit_q[2:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         chr_q   <= '0;
         hold_q  <= '0;
         addr_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= SETADDR;
                  busy_q  <= 1'b1;
                  addr_q  <= '0;
               end
            end
            SETADDR: begin
               state_q <= LATCH;
            end
            LATCH: begin
               hold_q  <= bus.regData;
               state_q <= SEND;
               tx_q    <= 1'b0;
               baud_q  <= BAUD_LAST;
               bit_q   <= '0;
               chr_q   <= '0;
            end
            SEND: begin
               if (baud_q != 16'd0) begin
                  baud_q <= baud_q - 16'd1;
               end else begin
                  baud_q <= BAUD_LAST;
                  if (bit_q == 4'd9) begin
                     bit_q <= '0;
                     if (chr_q == 4'd12) begin
                        state_q <= NEXT;
                        tx_q    <= 1'b1;
                        chr_q   <= '0;
                        baud_q  <= '0;
                     end else begin
                        chr_q <= chr_q + 4'd1;
                        tx_q  <= 1'b0;
                     end
                  end else begin
                     bit_q <= bit_q + 4'd1;
                     tx_q  <= tx_d;
                  end
               end
            end
            NEXT: begin
               if (addr_q < ADDR_LAST) begin
                  addr_q  <= addr_q + 5'd1;
                  state_q <= SETADDR;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.regAddr = addr_q;
   assign bus.uart_tx = tx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_sm_reg_uart_dump.sv
// Bench for sm_reg_uart_dump: three instances, UART decoders,
// string-level reference model of the dumped lines.
module tb_sm_reg_uart_dump;

   logic        clk;
   logic        rst;
   logic [31:0] cyc;
   logic        scr0;
   logic [31:0] seed0;
   logic [31:0] mem2 [2];

   localparam logic [31:0] GOLD = 32'h9E3779B9;

   sm_reg_uart_dump_if if0 ();
   sm_reg_uart_dump_if if1 ();
   sm_reg_uart_dump_if if2 ();

   sm_reg_uart_dump #(.BAUD_DIV(4), .NUM_REGS(1)) u0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.master)
   );
   sm_reg_uart_dump #(.BAUD_DIV(4), .NUM_REGS(32)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.master)
   );
   sm_reg_uart_dump #(.BAUD_DIV(2), .NUM_REGS(2)) u2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.master)
   );

   assign if0.regData = scr0 ? ((cyc * GOLD) ^ seed0) : 32'hDEADBEEF;
   assign if1.regData = ~{27'b0, if1.regAddr};
   assign if2.regData = mem2[if2.regAddr[0]];

   logic       tx     [3];
   logic       busy_s [3];
   logic       done_s [3];
   logic [4:0] addr_s [3];

   assign tx[0] = if0.uart_tx;
   assign tx[1] = if1.uart_tx;
   assign tx[2] = if2.uart_tx;
   assign busy_s[0] = if0.busy;
   assign busy_s[1] = if1.busy;
   assign busy_s[2] = if2.busy;
   assign done_s[0] = if0.done;
   assign done_s[1] = if1.done;
   assign done_s[2] = if2.done;
   assign addr_s[0] = if0.regAddr;
   assign addr_s[1] = if1.regAddr;
   assign addr_s[2] = if2.regAddr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // activity monitor
   int         busycnt [3];
   int         donecnt [3];
   logic [31:0] donecyc [3];
   logic [31:0] risecyc [3];
   logic       pbusy [3];
   logic [4:0] paddr1;
   int         steps1;
   int         badsteps1;

   initial begin
      for (int i = 0; i < 3; i++) begin
         busycnt[i] = 0;
         donecnt[i] = 0;
         donecyc[i] = '0;
         risecyc[i] = '0;
         pbusy[i]   = 1'b0;
      end
      paddr1    = '0;
      steps1    = 0;
      badsteps1 = 0;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (busy_s[i] === 1'b1) busycnt[i] <= busycnt[i] + 1;
         if (done_s[i] === 1'b1) begin
            donecnt[i] <= donecnt[i] + 1;
            donecyc[i] <= cyc;
         end
         if (busy_s[i] === 1'b1 && pbusy[i] !== 1'b1) risecyc[i] <= cyc;
         pbusy[i] <= busy_s[i];
      end
      if (busy_s[1] === 1'b1 && addr_s[1] !== paddr1) begin
         steps1 <= steps1 + 1;
         if (addr_s[1] !== paddr1 + 5'd1) badsteps1 <= badsteps1 + 1;
      end
      paddr1 <= addr_s[1];
   end

   // UART decoders: one per instance, sampling on the falling clock edge
   typedef struct {
      int          id;
      logic [7:0]  ch;
      logic [31:0] t;
      logic        bad;
   } rx_t;

   rx_t rxq [$];

   task automatic rx(input int id, input int bd);
      rx_t        e;
      logic [9:0] bits;
      logic       prev;
      logic       ab;
      forever begin
         @(negedge clk);
         if (tx[id] === 1'b0 && rst !== 1'b1) begin
            e.id  = id;
            e.t   = cyc;
            e.bad = 1'b0;
            e.ch  = '0;
            bits  = '0;
            prev  = 1'b0;
            ab    = 1'b0;
            for (int t = 1; t < 10 * bd; t++) begin
               @(negedge clk);
               if (rst === 1'b1) begin
                  ab = 1'b1;
                  break;
               end
               if ((t % bd) != 0 && tx[id] !== prev) e.bad = 1'b1;
               prev = tx[id];
               if ((t % bd) == bd / 2) bits[t / bd] = tx[id];
            end
            if (!ab) begin
               if (bits[0] !== 1'b0 || bits[9] !== 1'b1) e.bad = 1'b1;
               e.ch = bits[8:1];
               rxq.push_back(e);
            end
         end
      end
   endtask

   initial rx(0, 4);
   initial rx(1, 4);
   initial rx(2, 2);

   // checking helpers
   int checks;
   int errors;
   string exp_lines [$];

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, obs, obs, exp, exp);
      end
   endtask

   task automatic chks(input string tag, input string obs, input string exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
      end
   endtask

   function automatic string hexs(input logic [31:0] v, input int n);
      string digits;
      string s;
      logic [3:0] d;
      digits = "0123456789ABCDEF";
      s = "";
      for (int i = n - 1; i >= 0; i--) begin
         d = v[i*4 +: 4];
         s = $sformatf("%s%c", s, digits.getc(int'(d)));
      end
      return s;
   endfunction

   function automatic string line_of(input int a, input logic [31:0] v);
      return {hexs(32'(a), 2), ":", hexs(v, 8)};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int id, input int n0, input int lim,
                            input string tag);
      int k;
      k = 0;
      while (donecnt[id] == n0 && k < lim) begin
         step(1);
         k++;
      end
      chk({tag, " done within bound"}, longint'(donecnt[id] != n0), 1);
   endtask

   // s: cycle count just before the start edge; first start bit at s+3
   task automatic check_dump(input string tag, input int id,
                             input logic [31:0] s, input int bd);
      int nbad;
      int n;
      string got;
      logic [31:0] et;
      nbad = 0;
      chk({tag, " char count"}, rxq.size(), exp_lines.size() * 13);
      for (int l = 0; l < exp_lines.size(); l++) begin
         got = "";
         for (int c = 0; c < 13; c++) begin
            n = l * 13 + c;
            if (n < rxq.size()) begin
               et = s + 32'(3 + l * (3 + 130 * bd) + c * 10 * bd);
               if (c < 11) got = $sformatf("%s%c", got, rxq[n].ch);
               if (c == 11 && rxq[n].ch !== 8'h0D) nbad++;
               if (c == 12 && rxq[n].ch !== 8'h0A) nbad++;
               if (rxq[n].bad) nbad++;
               if (rxq[n].id != id) nbad++;
               if (rxq[n].t !== et) nbad++;
            end
         end
         chks($sformatf("%s line %0d", tag, l), got, exp_lines[l]);
      end
      chk({tag, " framing/timing/CRLF"}, nbad, 0);
      rxq.delete();
      exp_lines.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] s;
   logic [31:0] dA;
   int b0;
   int d0;

   initial begin
      checks = 0;
      errors = 0;
      scr0 = 1'b0;
      seed0 = $urandom;
      mem2[0] = $urandom;
      mem2[1] = $urandom;
      if0.start = 1'b0;
      if1.start = 1'b0;
      if2.start = 1'b0;
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step(1);

      // reset state of every instance
      chk("rst tx0", if0.uart_tx, 1);
      chk("rst busy0", if0.busy, 0);
      chk("rst done0", if0.done, 0);
      chk("rst addr0", if0.regAddr, 0);
      chk("rst tx1", if1.uart_tx, 1);
      chk("rst busy1", if1.busy, 0);
      chk("rst done1", if1.done, 0);
      chk("rst addr1", if1.regAddr, 0);
      chk("rst tx2", if2.uart_tx, 1);
      chk("rst busy2", if2.busy, 0);
      chk("rst done2", if2.done, 0);
      chk("rst addr2", if2.regAddr, 0);

      // single register, constant word
      rxq.delete();
      b0 = busycnt[0];
      d0 = donecnt[0];
      s = cyc;
      if0.start = 1'b1;
      step(1);
      if0.start = 1'b0;
      chk("A busy after start", if0.busy, 1);
      chk("A addr after start", if0.regAddr, 0);
      wait_done(0, d0, 1000, "A");
      chk("A done cycle", donecyc[0], s + 32'd524);
      step(5);
      chk("A done pulses", donecnt[0] - d0, 1);
      chk("A busy cycles", busycnt[0] - b0, 523);
      chk("A busy low after", if0.busy, 0);
      exp_lines.push_back(line_of(0, 32'hDEADBEEF));
      check_dump("A", 0, s, 4);

      // data scrambled every cycle: only the value at the latch edge counts
      scr0 = 1'b1;
      d0 = donecnt[0];
      s = cyc;
      if0.start = 1'b1;
      step(1);
      if0.start = 1'b0;
      wait_done(0, d0, 1000, "B");
      step(3);
      exp_lines.push_back(line_of(0, (s + 32'd2) * GOLD ^ seed0));
      check_dump("B", 0, s, 4);
      scr0 = 1'b0;

      // rst and start together: rst wins, start re-sampled afterwards
      rst = 1'b1;
      if0.start = 1'b1;
      step(1);
      chk("C busy with rst", if0.busy, 0);
      rst = 1'b0;
      d0 = donecnt[0];
      s = cyc;
      step(1);
      if0.start = 1'b0;
      chk("C busy after rst", if0.busy, 1);
      wait_done(0, d0, 1000, "C");
      step(3);
      exp_lines.push_back(line_of(0, 32'hDEADBEEF));
      check_dump("C", 0, s, 4);

      // reset in the middle of the fifth character
      rxq.delete();
      d0 = donecnt[1];
      if1.start = 1'b1;
      step(1);
      if1.start = 1'b0;
      for (int k = 0; k < 1000 && rxq.size() < 4; k++) step(1);
      chk("D four chars before rst", rxq.size(), 4);
      step(8);
      rst = 1'b1;
      step(1);
      chk("D tx after rst", if1.uart_tx, 1);
      chk("D busy after rst", if1.busy, 0);
      chk("D addr after rst", if1.regAddr, 0);
      chk("D done after rst", if1.done, 0);
      rst = 1'b0;
      step(60);
      chk("D no partial char", rxq.size(), 4);
      chk("D no done", donecnt[1] - d0, 0);
      rxq.delete();

      // full 32-register dump after the abort
      b0 = busycnt[1];
      d0 = donecnt[1];
      dA = 32'(steps1);
      s = cyc;
      if1.start = 1'b1;
      step(1);
      if1.start = 1'b0;
      wait_done(1, d0, 20000, "E");
      chk("E done cycle", donecyc[1], s + 32'd1 + 32'd16736);
      step(5);
      chk("E busy cycles", busycnt[1] - b0, 16736);
      chk("E done pulses", donecnt[1] - d0, 1);
      chk("E addr steps", steps1 - int'(dA), 31);
      chk("E bad addr steps", badsteps1, 0);
      chk("E addr holds last", if1.regAddr, 31);
      for (int a = 0; a < 32; a++) exp_lines.push_back(line_of(a, ~32'(a)));
      check_dump("E", 1, s, 4);

      // start held high, minimum baud divisor
      b0 = busycnt[2];
      d0 = donecnt[2];
      s = cyc;
      if2.start = 1'b1;
      wait_done(2, d0, 2000, "F1");
      dA = donecyc[2];
      chk("F1 done cycle", dA, s + 32'd527);
      chk("F1 single dump", donecnt[2] - d0, 1);
      if2.start = 1'b0;
      exp_lines.push_back(line_of(0, mem2[0]));
      exp_lines.push_back(line_of(1, mem2[1]));
      check_dump("F1", 2, s, 2);
      step(2);
      chk("F2 restart cycle", risecyc[2], dA + 32'd1);
      wait_done(2, d0 + 1, 2000, "F2");
      step(5);
      chk("F2 done pulses", donecnt[2] - d0, 2);
      chk("F busy cycles", busycnt[2] - b0, 1052);
      exp_lines.push_back(line_of(0, mem2[0]));
      exp_lines.push_back(line_of(1, mem2[1]));
      check_dump("F2", 2, dA, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
